// File: rtl/fetch_queue_pkg.sv
// Shared front-end sizing constants for the fetch path.
package cpu_sizes;
    localparam int unsigned INSTR_WINDOW     = 2;
    localparam int unsigned FQ_DEPTH_DEFAULT = 8;

    typedef logic [31:0] word_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-window input, decode-side output and status of the fetch queue.
interface fetch_queue_if #(
    parameter int unsigned FQ_DEPTH = cpu_sizes::FQ_DEPTH_DEFAULT
);
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;

    logic                                            FQ_FLUSH;
    logic                                            FQ_IN_VALID;
    logic [cpu_sizes::INSTR_WINDOW-1:0][31:0]        FQ_IN_PC;
    logic [cpu_sizes::INSTR_WINDOW-1:0][31:0]        FQ_IN_INSTR;
    logic                                            FQ_IN_READY;
    logic                                            FQ_OUT_VALID;
    logic [31:0]                                     FQ_OUT_PC;
    logic [31:0]                                     FQ_OUT_INSTR;
    logic                                            FQ_OUT_READY;
    logic [CNT_W-1:0]                                FQ_COUNT;

    modport master (
        output FQ_FLUSH, FQ_IN_VALID, FQ_IN_PC, FQ_IN_INSTR, FQ_OUT_READY,
        input  FQ_IN_READY, FQ_OUT_VALID, FQ_OUT_PC, FQ_OUT_INSTR, FQ_COUNT
    );

    modport slave (
        input  FQ_FLUSH, FQ_IN_VALID, FQ_IN_PC, FQ_IN_INSTR, FQ_OUT_READY,
        output FQ_IN_READY, FQ_OUT_VALID, FQ_OUT_PC, FQ_OUT_INSTR, FQ_COUNT
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: accepts INSTR_WINDOW instructions per push, hands one per pop
// to decode.
module fetch_queue
    import cpu_sizes::*;
#(
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic          FQ_CLK,
    input  logic          FQ_RST,
    fetch_queue_if.slave  fq
);
    localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if ((FQ_DEPTH & (FQ_DEPTH - 1)) != 0 || FQ_DEPTH < 2 * INSTR_WINDOW) begin : g_bad_depth
        $error("fetch_queue: FQ_DEPTH must be a power of two and >= 2*INSTR_WINDOW");
    end

    word_t            r_pc_mem    [FQ_DEPTH];
    word_t            r_instr_mem [FQ_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Readiness looks only at the registered count; a same-cycle pop earns no credit.
    assign w_in_ready  = (r_count <= CNT_W'(FQ_DEPTH - INSTR_WINDOW)) && !fq.FQ_FLUSH && !FQ_RST;
    assign w_out_valid = (r_count != '0);
    assign w_push      = fq.FQ_IN_VALID && w_in_ready;
    assign w_pop       = w_out_valid && fq.FQ_OUT_READY && !fq.FQ_FLUSH;

    always_comb begin
        w_count_nxt = r_count;
        if (fq.FQ_FLUSH) begin
            w_count_nxt = '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(INSTR_WINDOW);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                2'b11:   w_count_nxt = r_count + CNT_W'(INSTR_WINDOW - 1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge FQ_CLK or posedge FQ_RST) begin
        if (FQ_RST) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (fq.FQ_FLUSH) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_W'(INSTR_WINDOW);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Storage is never read while empty, so it carries no reset.
    always_ff @(posedge FQ_CLK) begin
        if (w_push) begin
            for (int i = 0; i < int'(INSTR_WINDOW); i++) begin
                r_pc_mem[r_wptr + PTR_W'(i)]    <= fq.FQ_IN_PC[i];
                r_instr_mem[r_wptr + PTR_W'(i)] <= fq.FQ_IN_INSTR[i];
            end
        end
    end

    assign fq.FQ_IN_READY  = w_in_ready;
    assign fq.FQ_OUT_VALID = w_out_valid;
    assign fq.FQ_OUT_PC    = w_out_valid ? r_pc_mem[r_rptr]    : '0;
    assign fq.FQ_OUT_INSTR = w_out_valid ? r_instr_mem[r_rptr] : '0;
    assign fq.FQ_COUNT     = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import cpu_sizes::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = INSTR_WINDOW;

    logic clk;
    logic rst;

    fetch_queue_if #(.FQ_DEPTH(DEPTH)) fq_bus ();

    fetch_queue #(.FQ_DEPTH(DEPTH)) dut (
        .FQ_CLK (clk),
        .FQ_RST (rst),
        .fq     (fq_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  n_checks;
    int unsigned  n_pass;
    logic [63:0]  model_q[$];  // {pc, instr}, front is the head
    logic         last_push;
    logic [31:0]  next_pc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic compare(input string tag);
        logic        exp_valid;
        logic [63:0] head;
        logic        exp_ready;
        exp_valid = (model_q.size() != 0);
        head      = exp_valid ? model_q[0] : 64'h0;
        exp_ready = (model_q.size() <= int'(DEPTH - W)) && !fq_bus.FQ_FLUSH && !rst;
        check_eq({tag, ".count"}, 64'(fq_bus.FQ_COUNT), 64'(model_q.size()));
        check_eq({tag, ".valid"}, 64'(fq_bus.FQ_OUT_VALID), 64'(exp_valid));
        check_eq({tag, ".pc"}, 64'(fq_bus.FQ_OUT_PC), 64'(head[63:32]));
        check_eq({tag, ".instr"}, 64'(fq_bus.FQ_OUT_INSTR), 64'(head[31:0]));
        check_eq({tag, ".in_ready"}, 64'(fq_bus.FQ_IN_READY), 64'(exp_ready));
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc0, input logic out_ready,
                         input logic flush);
        fq_bus.FQ_IN_VALID  = valid;
        fq_bus.FQ_OUT_READY = out_ready;
        fq_bus.FQ_FLUSH     = flush;
        for (int i = 0; i < int'(W); i++) begin
            fq_bus.FQ_IN_PC[i]    = pc0 + 32'(4 * i);
            fq_bus.FQ_IN_INSTR[i] = $urandom;
        end
    endtask

    // Advance one clock edge, step the model with the inputs that edge saw, then compare.
    task automatic step(input string tag);
        logic do_push;
        logic do_pop;
        @(posedge clk);
        do_push = fq_bus.FQ_IN_VALID && (model_q.size() <= int'(DEPTH - W)) &&
                  !fq_bus.FQ_FLUSH && !rst;
        do_pop  = (model_q.size() != 0) && fq_bus.FQ_OUT_READY && !fq_bus.FQ_FLUSH && !rst;
        if (fq_bus.FQ_FLUSH || rst) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push)
                for (int i = 0; i < int'(W); i++)
                    model_q.push_back({fq_bus.FQ_IN_PC[i], fq_bus.FQ_IN_INSTR[i]});
        end
        last_push = do_push;
        #1;
        compare(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        last_push = 1'b0;
        rst       = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        compare("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Single window drains in order.
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        fq_bus.FQ_IN_INSTR[0] = 32'hA;
        fq_bus.FQ_IN_INSTR[1] = 32'hB;
        step("first_push");
        check_eq("first_head_pc", 64'(fq_bus.FQ_OUT_PC), 64'h100);
        check_eq("first_head_instr", 64'(fq_bus.FQ_OUT_INSTR), 64'hA);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step("drain1");
        check_eq("second_head_pc", 64'(fq_bus.FQ_OUT_PC), 64'h104);
        step("drain2");
        check_eq("drained_count", 64'(fq_bus.FQ_COUNT), 64'd0);

        // Fill to capacity; a window offered while full is ignored.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h200 + 32'(8 * k), 1'b0, 1'b0);
            step("fill");
        end
        check_eq("full_count", 64'(fq_bus.FQ_COUNT), 64'd8);
        check_eq("full_not_ready", 64'(fq_bus.FQ_IN_READY), 64'd0);
        check_eq("full_head", 64'(fq_bus.FQ_OUT_PC), 64'h200);

        // Count 3, then simultaneous push and pop.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("flush_full");
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        step("to2");
        drive(1'b1, 32'h308, 1'b1, 1'b0);
        step("to3");
        drive(1'b1, 32'h310, 1'b1, 1'b0);
        step("pushpop");
        check_eq("pushpop_count", 64'(fq_bus.FQ_COUNT), 64'd4);
        check_eq("pushpop_head", 64'(fq_bus.FQ_OUT_PC), 64'h308);

        // Count 5, then flush with valid and ready both high.
        drive(1'b1, 32'h320, 1'b0, 1'b0);
        step("to6");
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step("to5");
        check_eq("at5", 64'(fq_bus.FQ_COUNT), 64'd5);
        drive(1'b1, 32'h400, 1'b1, 1'b1);
        step("flush5");
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        compare("after_flush");

        // Stream 12 windows across several wraps.
        next_pc = 32'h0;
        for (int c = 0; c < 200 && (next_pc < 32'h60 || model_q.size() != 0); c++) begin
            drive(next_pc < 32'h60, next_pc, 1'b1, 1'b0);
            step("stream");
            if (last_push) next_pc += 32'(4 * W);
        end
        check_eq("stream_sent", 64'(next_pc), 64'h60);
        check_eq("stream_empty", 64'(fq_bus.FQ_COUNT), 64'd0);

        // Asynchronous reset mid-cycle at count 5.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h500 + 32'(8 * k), 1'b0, 1'b0);
            step("prerst_fill");
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step("prerst_pop");
        check_eq("prerst_count", 64'(fq_bus.FQ_COUNT), 64'd5);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_q.delete();
        #1;
        compare("async_rst");
        #2;
        rst = 1'b0;
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        step("post_rst_push");
        check_eq("post_rst_accept", 64'(last_push), 64'd1);

        // Random traffic.
        next_pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), next_pc, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 24) == 0));
            step("rand");
            if (last_push) next_pc += 32'(4 * W);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
